// File: rtl/mips_pkg.sv
// Shared pipeline types for the MEM stage.
//   state_e  : memory-access FSM states
//   mem_wb_t : MEM/WB payload {reg_write, data, rd}
//   BUBBLE   : all-zero MEM/WB payload (no write-back)
package mips_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef struct packed {
        logic                  reg_write;
        logic [WORD_W-1:0]     data;
        logic [REG_ADDR_W-1:0] rd;
    } mem_wb_t;

    localparam mem_wb_t BUBBLE = '0;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB field register: captures the offered fields when load_i is high,
// otherwise inserts a bubble.
//   clk, rst  : clock, async active-low reset
//   load_i    : 1 = capture fields_i, 0 = capture BUBBLE
//   fields_i  : candidate MEM/WB payload
//   fields_o  : registered MEM/WB payload
module mem_wb_reg
    import mips_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load_i,
    input  mem_wb_t fields_i,
    output mem_wb_t fields_o
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fields_o <= BUBBLE;
        end else begin
            fields_o <= load_i ? fields_i : BUBBLE;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues data-memory requests from the EX/MEM register, stalls the
// front of the pipe while an access is in flight, resolves branches and loads
// MEM/WB with either the instruction result or a bubble.
//   EX/MEM in : Branch_in, MemRead_in, MemWrite_in, RegWrite_in, Zero_in,
//               ALU_in, FwdBOut_in, Rd_in
//   memory    : dm_req, dm_we, dm_addr, dm_wdata (registered); dm_ack, dm_rdata
//   pipeline  : stall, PCSrc (combinational)
//   MEM/WB out: RegWrite_out, WbData_out, Rd_out
//   errors    : misalign_err, timeout_err (sticky until reset)
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = $clog2(MAX_WAIT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Branch_in,
    input  logic                  MemRead_in,
    input  logic                  MemWrite_in,
    input  logic                  RegWrite_in,
    input  logic                  Zero_in,
    input  logic [WORD_W-1:0]     ALU_in,
    input  logic [WORD_W-1:0]     FwdBOut_in,
    input  logic [REG_ADDR_W-1:0] Rd_in,
    output logic                  dm_req,
    output logic                  dm_we,
    output logic [WORD_W-1:0]     dm_addr,
    output logic [WORD_W-1:0]     dm_wdata,
    input  logic                  dm_ack,
    input  logic [WORD_W-1:0]     dm_rdata,
    output logic                  stall,
    output logic                  PCSrc,
    output logic                  RegWrite_out,
    output logic [WORD_W-1:0]     WbData_out,
    output logic [REG_ADDR_W-1:0] Rd_out,
    output logic                  misalign_err,
    output logic                  timeout_err
);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [WORD_W-1:0]     addr_q, addr_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic                  lat_rw_q, lat_rw_d;
    logic                  lat_load_q, lat_load_d;
    logic [REG_ADDR_W-1:0] lat_rd_q, lat_rd_d;
    logic [WORD_W-1:0]     lat_alu_q, lat_alu_d;
    logic [WORD_W-1:0]     result_q, result_d;
    logic                  valid_q, valid_d;
    logic                  mis_q, mis_d;
    logic                  to_q, to_d;

    logic    memop, aligned, at_limit;
    logic    mw_load;
    mem_wb_t mw_fields, mw_q;

    assign memop    = MemRead_in | MemWrite_in;
    assign aligned  = (ALU_in[1:0] == 2'b00);
    assign at_limit = (cnt_q == CNT_W'(MAX_WAIT - 1));

    // Stall is forced low while in reset so a held instruction cannot freeze the pipe.
    assign stall = rst & (((state_q == IDLE) & memop & aligned) | (state_q == ACCESS));
    assign PCSrc = (state_q == IDLE) & Branch_in & Zero_in;

    // Next-state, request and MEM/WB selection.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lat_rw_d   = lat_rw_q;
        lat_load_d = lat_load_q;
        lat_rd_d   = lat_rd_q;
        lat_alu_d  = lat_alu_q;
        result_d   = result_q;
        valid_d    = valid_q;
        mis_d      = mis_q;
        to_d       = to_q;
        mw_load    = 1'b0;
        mw_fields  = BUBBLE;

        unique case (state_q)
            IDLE: begin
                if (!memop) begin
                    mw_load   = 1'b1;
                    mw_fields = '{reg_write: RegWrite_in, data: ALU_in, rd: Rd_in};
                end else if (!aligned) begin
                    mis_d = 1'b1;
                end else begin
                    req_d      = 1'b1;
                    we_d       = MemWrite_in;
                    addr_d     = {ALU_in[WORD_W-1:2], 2'b00};
                    wdata_d    = FwdBOut_in;
                    // Read+write together executes as a write with no write-back.
                    lat_rw_d   = RegWrite_in & ~(MemRead_in & MemWrite_in);
                    lat_load_d = MemRead_in & ~MemWrite_in;
                    lat_rd_d   = Rd_in;
                    lat_alu_d  = ALU_in;
                    cnt_d      = '0;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                // Ack takes priority over the wait limit.
                if (dm_ack) begin
                    req_d    = 1'b0;
                    result_d = lat_load_q ? dm_rdata : lat_alu_q;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else if (at_limit) begin
                    req_d    = 1'b0;
                    result_d = '0;
                    valid_d  = 1'b0;
                    to_d     = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                mw_load   = 1'b1;
                mw_fields = '{reg_write: lat_rw_q & valid_q, data: result_q, rd: lat_rd_q};
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_rw_q   <= 1'b0;
            lat_load_q <= 1'b0;
            lat_rd_q   <= '0;
            lat_alu_q  <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            mis_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lat_rw_q   <= lat_rw_d;
            lat_load_q <= lat_load_d;
            lat_rd_q   <= lat_rd_d;
            lat_alu_q  <= lat_alu_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            mis_q      <= mis_d;
            to_q       <= to_d;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk      (clk),
        .rst      (rst),
        .load_i   (mw_load),
        .fields_i (mw_fields),
        .fields_o (mw_q)
    );

    assign dm_req       = req_q;
    assign dm_we        = we_q;
    assign dm_addr      = addr_q;
    assign dm_wdata     = wdata_q;
    assign RegWrite_out = mw_q.reg_write;
    assign WbData_out   = mw_q.data;
    assign Rd_out       = mw_q.rd;
    assign misalign_err = mis_q;
    assign timeout_err  = to_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: the bench plays the data memory
// (associative array) and predicts every MEM/WB value from the instruction.
module tb_mem_access_unit;

    localparam int MAX_WAIT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        Branch_in, MemRead_in, MemWrite_in, RegWrite_in, Zero_in;
    logic [31:0] ALU_in, FwdBOut_in;
    logic [4:0]  Rd_in;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stall, PCSrc, RegWrite_out;
    logic [31:0] WbData_out;
    logic [4:0]  Rd_out;
    logic        misalign_err, timeout_err;

    int checks = 0;
    int errors = 0;
    logic exp_mis = 1'b0;
    logic exp_to  = 1'b0;
    logic [31:0] mem [logic [31:0]];

    mem_access_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .Branch_in(Branch_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .RegWrite_in(RegWrite_in), .Zero_in(Zero_in), .ALU_in(ALU_in),
        .FwdBOut_in(FwdBOut_in), .Rd_in(Rd_in),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall(stall), .PCSrc(PCSrc),
        .RegWrite_out(RegWrite_out), .WbData_out(WbData_out), .Rd_out(Rd_out),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive_nop();
        Branch_in = 0; MemRead_in = 0; MemWrite_in = 0; RegWrite_in = 0; Zero_in = 0;
        ALU_in = '0; FwdBOut_in = '0; Rd_in = '0; dm_ack = 0; dm_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_nop();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dm_req, dm_we, dm_addr, dm_wdata, stall, PCSrc, RegWrite_out, WbData_out, Rd_out,
             misalign_err, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h stall=%b pcsrc=%b rw=%b wb=%h rd=%0d mis=%b to=%b, required all 0",
                     dm_req, dm_we, dm_addr, dm_wdata, stall, PCSrc, RegWrite_out, WbData_out, Rd_out,
                     misalign_err, timeout_err);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Non-memory instructions, with random branch inputs and stray acks.
    task automatic test_alu(input int n, input bit directed);
        logic rw, br, z;
        logic [31:0] alu;
        logic [4:0] rd;
        for (int i = 0; i < n; i++) begin
            rw = 1'($urandom); alu = $urandom; rd = 5'($urandom);
            br = 1'($urandom); z = 1'($urandom);
            if (directed && i == 0) begin rw = 1; alu = 32'h1234; rd = 5'd5; br = 0; z = 0; end
            if (directed && i == 1) begin br = 1; z = 1; end
            if (directed && i == 2) begin br = 1; z = 0; end
            Branch_in = br; Zero_in = z; MemRead_in = 0; MemWrite_in = 0;
            RegWrite_in = rw; ALU_in = alu; Rd_in = rd; FwdBOut_in = $urandom;
            dm_ack = 1'($urandom); dm_rdata = $urandom;
            #1;
            checks++;
            if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b required 0", stall); end
            checks++;
            if (PCSrc !== (br & z)) begin
                errors++; $display("FAIL pcsrc: br=%b z=%b got %b required %b", br, z, PCSrc, br & z);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({RegWrite_out, WbData_out, Rd_out} !== {rw, alu, rd}) begin
                errors++;
                $display("FAIL alu_wb: got rw=%b data=%h rd=%0d required rw=%b data=%h rd=%0d",
                         RegWrite_out, WbData_out, Rd_out, rw, alu, rd);
            end
            checks++;
            if (dm_req !== 1'b0) begin errors++; $display("FAIL alu_no_req: dm_req=%b required 0", dm_req); end
        end
        drive_nop();
    endtask

    // One aligned memory op; ack_at = ACCESS cycle carrying the ack (0 = never).
    task automatic test_memop(input logic rdf, input logic wrf, input logic rw, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [4:0] rd, input int ack_at);
        logic [31:0] waddr, rdata, exp_data;
        logic valid, exp_rw;
        int k, stall_cycles;
        bit fin;
        waddr = {addr[31:2], 2'b00};
        if (!mem.exists(waddr)) mem[waddr] = $urandom;
        rdata = mem[waddr];
        valid = (ack_at >= 1 && ack_at <= MAX_WAIT);
        Branch_in = 0; Zero_in = 0; MemRead_in = rdf; MemWrite_in = wrf; RegWrite_in = rw;
        ALU_in = addr; FwdBOut_in = wd; Rd_in = rd; dm_ack = 0;
        #1;
        stall_cycles = (stall === 1'b1) ? 1 : 0;
        @(posedge clk);
        #1;
        checks++;
        if ({dm_req, dm_we, dm_addr, dm_wdata} !== {1'b1, wrf, waddr, wd}) begin
            errors++;
            $display("FAIL issue: got req=%b we=%b addr=%h wdata=%h required req=1 we=%b addr=%h wdata=%h",
                     dm_req, dm_we, dm_addr, dm_wdata, wrf, waddr, wd);
        end
        checks++;
        if (RegWrite_out !== 1'b0) begin errors++; $display("FAIL issue_bubble: RegWrite_out=%b required 0", RegWrite_out); end
        k = 0; fin = 0;
        while (!fin) begin
            k++;
            dm_ack = (k == ack_at);
            dm_rdata = dm_ack ? rdata : $urandom;
            #1;
            if (stall === 1'b1) stall_cycles++;
            checks++;
            if ({dm_req, dm_addr} !== {1'b1, waddr}) begin
                errors++; $display("FAIL access_hold: cycle %0d req=%b addr=%h required 1/%h", k, dm_req, dm_addr, waddr);
            end
            @(posedge clk);
            #1;
            dm_ack = 0;
            if (k == ack_at || k >= MAX_WAIT) fin = 1;
        end
        if (valid && wrf) mem[waddr] = wd;
        if (!valid) exp_to = 1'b1;
        checks++;
        if (stall_cycles !== 1 + k) begin
            errors++; $display("FAIL stall_cycles: got %0d required %0d", stall_cycles, 1 + k);
        end
        checks++;
        if ({dm_req, stall, RegWrite_out, timeout_err, misalign_err} !== {3'b000, exp_to, exp_mis}) begin
            errors++;
            $display("FAIL done_state: req=%b stall=%b rw=%b to=%b mis=%b required 0 0 0 %b %b",
                     dm_req, stall, RegWrite_out, timeout_err, misalign_err, exp_to, exp_mis);
        end
        exp_rw   = rw & ~(rdf & wrf) & valid;
        exp_data = (rdf & ~wrf) ? rdata : addr;
        @(posedge clk);
        #1;
        checks++;
        if ({RegWrite_out, Rd_out} !== {exp_rw, rd}) begin
            errors++; $display("FAIL memop_wb: got rw=%b rd=%0d required rw=%b rd=%0d", RegWrite_out, Rd_out, exp_rw, rd);
        end
        if (valid) begin
            checks++;
            if (WbData_out !== exp_data) begin
                errors++; $display("FAIL memop_data: got %h required %h", WbData_out, exp_data);
            end
        end
        drive_nop();
        @(posedge clk);
        #1;
        checks++;
        if (dm_req !== 1'b0) begin errors++; $display("FAIL reissue: dm_req=%b required 0", dm_req); end
    endtask

    task automatic test_random_memops(input int n);
        logic rdf, wrf;
        for (int i = 0; i < n; i++) begin
            rdf = 1'($urandom); wrf = rdf ? 1'($urandom) : 1'b1;
            test_memop(rdf, wrf, 1'($urandom), {27'($urandom_range(0, 7)), 3'b000} | 32'(4 * $urandom_range(0, 1)),
                       $urandom, 5'($urandom), $urandom_range(1, 4));
        end
    endtask

    task automatic test_misalign(input int n);
        logic rdf, wrf;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            rdf = 1'($urandom); wrf = rdf ? 1'($urandom) : 1'b1;
            a = $urandom;
            a[1:0] = 2'($urandom_range(1, 3));
            if (i == 0) begin rdf = 1; wrf = 0; a = 32'h102; end
            MemRead_in = rdf; MemWrite_in = wrf; RegWrite_in = 1; ALU_in = a;
            FwdBOut_in = $urandom; Rd_in = 5'($urandom_range(1, 31)); dm_ack = 1'($urandom);
            #1;
            checks++;
            if (stall !== 1'b0) begin errors++; $display("FAIL misalign_stall: got %b required 0", stall); end
            @(posedge clk);
            #1;
            exp_mis = 1'b1;
            checks++;
            if ({dm_req, misalign_err, RegWrite_out, WbData_out, Rd_out} !== {1'b0, 1'b1, 38'd0}) begin
                errors++;
                $display("FAIL misalign: req=%b mis=%b rw=%b data=%h rd=%0d required 0 1 0 0 0",
                         dm_req, misalign_err, RegWrite_out, WbData_out, Rd_out);
            end
        end
        drive_nop();
    endtask

    task automatic test_reset_mid_access();
        MemRead_in = 1; ALU_in = 32'h300; RegWrite_in = 1; Rd_in = 5'd9;
        @(posedge clk);
        #1;
        checks++;
        if (dm_req !== 1'b1) begin errors++; $display("FAIL pre_reset_req: dm_req=%b required 1", dm_req); end
        #2;
        rst = 1'b0;
        #1;
        exp_mis = 1'b0; exp_to = 1'b0;
        checks++;
        if ({dm_req, stall, misalign_err, timeout_err, RegWrite_out} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset: req=%b stall=%b mis=%b to=%b rw=%b required all 0",
                     dm_req, stall, misalign_err, timeout_err, RegWrite_out);
        end
        drive_nop();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({dm_req, stall} !== 2'b00) begin
                errors++; $display("FAIL post_reset: cycle %0d req=%b stall=%b required 0 0", i, dm_req, stall);
            end
        end
    endtask

    initial begin
        drive_nop();
        test_reset();
        test_alu(10, 1'b1);
        mem[32'h100] = 32'hDEADBEEF;
        test_memop(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 5'd7, 2);
        test_memop(1'b0, 1'b1, 1'b0, 32'h204, 32'h0000CAFE, 5'd3, 1);
        test_memop(1'b1, 1'b1, 1'b1, 32'h208, 32'h12345678, 5'd4, 3);
        test_random_memops(12);
        test_misalign(4);
        test_memop(1'b1, 1'b0, 1'b1, 32'h040, 32'h0, 5'd11, MAX_WAIT);
        test_memop(1'b1, 1'b0, 1'b1, 32'h044, 32'h0, 5'd12, 0);
        test_reset_mid_access();
        test_alu(6, 1'b0);
        test_random_memops(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
